// File: rtl/riscv_pkg.sv
// Shared RISC-V control-flow encodings, sequencer state type and instruction classifier.
// Pure definitions: no logic, no latency.
package riscv_pkg;

  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;

  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;

  typedef enum logic {RUN, WAIT} bfc_state_t;

  typedef enum logic [1:0] {CF_NONE, CF_BR, CF_JAL, CF_JALR} cf_kind_t;

  // funct3 2/3 under the branch opcode are not legal branches and are treated as ordinary instructions.
  function automatic cf_kind_t cf_classify(input logic [6:0] op, input logic [2:0] f3);
    cf_kind_t k;
    k = CF_NONE;
    if (op == OP_BRANCH) begin
      if (f3 == F3_BEQ || f3 == F3_BNE || f3 == F3_BLT ||
          f3 == F3_BGE || f3 == F3_BLTU || f3 == F3_BGEU)
        k = CF_BR;
    end else if (op == OP_JAL) begin
      k = CF_JAL;
    end else if (op == OP_JALR) begin
      k = CF_JALR;
    end
    return k;
  endfunction

endpackage

// File: rtl/branch_hazard_detect.sv
// Stall-count lookup for branch/jump source operands vs. in-flight EX/MEM writers.
// Purely combinational; x0 never hazards; JAL has no sources.
import riscv_pkg::*;

module branch_hazard_detect (
  input  cf_kind_t   kind,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_regwrite,
  input  logic       ex_memread,
  input  logic [4:0] mem_rd,
  input  logic       mem_memread,
  output logic [1:0] need
);

  function automatic logic hit(input logic [4:0] r, input logic [4:0] d);
    return (r != 5'd0) && (r == d);
  endfunction

  logic use_rs1, use_rs2, ex_hit, mem_hit;

  assign use_rs1 = (kind == CF_BR) || (kind == CF_JALR);
  assign use_rs2 = (kind == CF_BR);
  assign ex_hit  = (use_rs1 && hit(rs1, ex_rd))  || (use_rs2 && hit(rs2, ex_rd));
  assign mem_hit = (use_rs1 && hit(rs1, mem_rd)) || (use_rs2 && hit(rs2, mem_rd));

  // Load in EX needs two cycles before its data reaches the ID comparator; ALU in EX or load in MEM needs one.
  always_comb begin
    need = 2'd0;
    if (ex_hit && ex_memread)       need = 2'd2;
    else if (ex_hit && ex_regwrite) need = 2'd1;
    else if (mem_hit && mem_memread) need = 2'd1;
  end

endmodule

// File: rtl/branch_flow_ctrl.sv
// ID-stage branch/jump sequencer: hazard stall, zero-cycle redirect + IF/ID flush, branch/taken counters.
// Outputs are combinational from state+inputs; ext_stall freezes all state and suppresses bubble/redirect.
import riscv_pkg::*;

module branch_flow_ctrl #(
  parameter int XLEN      = 32,
  parameter int CNT_W     = 32,
  parameter int MAX_STALL = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [6:0]       id_op,
  input  logic [2:0]       id_funct3,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_regwrite,
  input  logic             ex_memread,
  input  logic [4:0]       mem_rd,
  input  logic             mem_memread,
  input  logic             branch_taken,
  input  logic [XLEN-1:0]  target_pc,
  input  logic             ext_stall,
  output logic             stall_pc,
  output logic             stall_ifid,
  output logic             bubble_idex,
  output logic             flush_ifid,
  output logic             redirect,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam int SW = $clog2(MAX_STALL + 1);

  bfc_state_t  state;
  logic [SW-1:0] scnt;
  cf_kind_t    kind;
  logic [1:0]  need;
  logic        cf_active, stall, br_resolve;

  assign kind      = cf_classify(id_op, id_funct3);
  assign cf_active = id_valid && (kind != CF_NONE);

  branch_hazard_detect u_hazard (
    .kind        (kind),
    .rs1         (id_rs1),
    .rs2         (id_rs2),
    .ex_rd       (ex_rd),
    .ex_regwrite (ex_regwrite),
    .ex_memread  (ex_memread),
    .mem_rd      (mem_rd),
    .mem_memread (mem_memread),
    .need        (need)
  );

  // Stall and redirect are mutually exclusive by construction of this priority chain.
  always_comb begin
    stall      = 1'b0;
    redirect   = 1'b0;
    br_resolve = 1'b0;
    if (!rst && !ext_stall) begin
      if (state == WAIT) begin
        stall = 1'b1;
      end else if (cf_active) begin
        if (need != 2'd0) begin
          stall = 1'b1;
        end else if (kind == CF_BR) begin
          br_resolve = 1'b1;
          redirect   = branch_taken;
        end else begin
          redirect = 1'b1;
        end
      end
    end
  end

  assign stall_pc    = stall || (!rst && ext_stall);
  assign stall_ifid  = stall_pc;
  assign bubble_idex = stall;
  assign flush_ifid  = redirect;
  assign redirect_pc = redirect ? target_pc : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      scnt       <= '0;
      branch_cnt <= '0;
      taken_cnt  <= '0;
    end else if (!ext_stall) begin
      case (state)
        RUN: begin
          if (cf_active && need != 2'd0) begin
            state <= WAIT;
            scnt  <= SW'(need) - SW'(1);
          end
        end
        WAIT: begin
          if (scnt != '0) scnt <= scnt - SW'(1);
          else            state <= RUN;
        end
        default: state <= RUN;
      endcase
      if (br_resolve) begin
        branch_cnt <= branch_cnt + CNT_W'(1);
        if (branch_taken) taken_cnt <= taken_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_flow_ctrl.sv
// Directed bench for branch_flow_ctrl: per-cycle comparison against a behavioural model plus literal spot checks.
module tb_branch_flow_ctrl;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             id_valid = 1'b0;
  logic [6:0]       id_op = 7'h13;
  logic [2:0]       id_funct3 = 3'd0;
  logic [4:0]       id_rs1 = 5'd0, id_rs2 = 5'd0;
  logic [4:0]       ex_rd = 5'd0, mem_rd = 5'd0;
  logic             ex_regwrite = 1'b0, ex_memread = 1'b0, mem_memread = 1'b0;
  logic             branch_taken = 1'b0;
  logic [XLEN-1:0]  target_pc = '0;
  logic             ext_stall = 1'b0;
  logic             stall_pc, stall_ifid, bubble_idex, flush_ifid, redirect;
  logic [XLEN-1:0]  redirect_pc;
  logic [CNT_W-1:0] branch_cnt, taken_cnt;

  branch_flow_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W), .MAX_STALL(2)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_op(id_op), .id_funct3(id_funct3),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .mem_rd(mem_rd), .mem_memread(mem_memread),
    .branch_taken(branch_taken), .target_pc(target_pc), .ext_stall(ext_stall),
    .stall_pc(stall_pc), .stall_ifid(stall_ifid), .bubble_idex(bubble_idex),
    .flush_ifid(flush_ifid), .redirect(redirect), .redirect_pc(redirect_pc),
    .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_wait_left = 0;   // remaining frozen-ID cycles after the detecting cycle
  int m_br = 0, m_tk = 0;

  // 0 none, 1 conditional branch, 2 jal, 3 jalr
  function automatic int m_kind(input logic [6:0] op, input logic [2:0] f3);
    if (op == 7'h63) return (f3 == 3'd2 || f3 == 3'd3) ? 0 : 1;
    if (op == 7'h6F) return 2;
    if (op == 7'h67) return 3;
    return 0;
  endfunction

  function automatic int m_need_one(input logic [4:0] s);
    if (s == 5'd0) return 0;
    if (s == ex_rd && ex_memread) return 2;
    if (s == ex_rd && ex_regwrite) return 1;
    if (s == mem_rd && mem_memread) return 1;
    return 0;
  endfunction

  function automatic int m_need(input int k);
    int a, b;
    a = (k == 1 || k == 3) ? m_need_one(id_rs1) : 0;
    b = (k == 1) ? m_need_one(id_rs2) : 0;
    return (a > b) ? a : b;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      bit e_stall, e_bub, e_red;
      int k, n;
      logic [44:0] exp_v, act_v;
      e_stall = 0; e_bub = 0; e_red = 0;
      k = m_kind(id_op, id_funct3);
      n = m_need(k);
      if (rst) begin
        // all outputs low
      end else if (ext_stall) begin
        e_stall = 1;
      end else if (m_wait_left > 0) begin
        e_stall = 1; e_bub = 1;
        m_wait_left--;
      end else if (id_valid && k != 0) begin
        if (n > 0) begin
          e_stall = 1; e_bub = 1;
          m_wait_left = n;
        end else if (k == 1) begin
          e_red = branch_taken;
        end else begin
          e_red = 1;
        end
      end
      exp_v = {e_stall, e_stall, e_bub, e_red, e_red, (e_red ? target_pc : 32'h0),
               CNT_W'(m_br), CNT_W'(m_tk)};
      act_v = {stall_pc, stall_ifid, bubble_idex, flush_ifid, redirect, redirect_pc,
               branch_cnt, taken_cnt};
      chk("model_cycle", 64'(act_v), 64'(exp_v));
      if (!rst && !ext_stall && !e_stall && id_valid && k == 1) begin
        m_br = (m_br + 1) % (1 << CNT_W);
        if (branch_taken) m_tk = (m_tk + 1) % (1 << CNT_W);
      end
      if (rst) begin
        m_wait_left = 0; m_br = 0; m_tk = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] r1,
                           input logic [4:0] r2, input logic tk, input logic [31:0] tgt);
    id_valid = 1'b1; id_op = op; id_funct3 = f3; id_rs1 = r1; id_rs2 = r2;
    branch_taken = tk; target_pc = tgt;
  endtask

  task automatic clr_haz;
    ex_rd = 5'd0; ex_regwrite = 1'b0; ex_memread = 1'b0; mem_rd = 5'd0; mem_memread = 1'b0;
  endtask

  initial begin
    @(posedge clk); #1;
    chk_en = 1'b1;
    step(1);
    chk("reset_outputs", {59'd0, stall_pc, bubble_idex, flush_ifid, redirect, 1'b0}, 64'd0);
    chk("reset_counters", {56'd0, branch_cnt, taken_cnt}, 64'd0);
    rst = 1'b0;

    // 1: taken beq, no hazards -> same-cycle redirect
    set_instr(7'h63, 3'd0, 5'd5, 5'd6, 1'b1, 32'h100);
    settle;
    chk("t1_redirect", {62'd0, redirect, flush_ifid}, 64'd3);
    chk("t1_redirect_pc", 64'(redirect_pc), 64'h100);
    chk("t1_no_stall", 64'(stall_pc), 64'd0);
    step(1);
    id_valid = 1'b0;
    settle;
    chk("t1_counts", {56'd0, branch_cnt, taken_cnt}, {56'd0, 4'd1, 4'd1});

    // 2: load-use on rs1 -> detect cycle plus two WAIT cycles, then not-taken resolve
    set_instr(7'h63, 3'd1, 5'd5, 5'd7, 1'b0, 32'h180);
    ex_rd = 5'd5; ex_memread = 1'b1;
    settle;
    chk("t2_detect_stall", {61'd0, stall_pc, stall_ifid, bubble_idex}, 64'd7);
    step(1);
    clr_haz;
    settle;
    chk("t2_wait1_bubble", 64'(bubble_idex), 64'd1);
    step(1);
    chk("t2_wait0_bubble", 64'(bubble_idex), 64'd1);
    step(1);
    chk("t2_resolve_no_redirect", {62'd0, redirect, stall_pc}, 64'd0);
    step(1);
    id_valid = 1'b0;
    settle;
    chk("t2_counts", {56'd0, branch_cnt, taken_cnt}, {56'd0, 4'd2, 4'd1});

    // 3: jumps never hazard on x0 / JAL has no sources
    set_instr(7'h67, 3'd0, 5'd0, 5'd0, 1'b0, 32'h200);
    ex_rd = 5'd0; ex_regwrite = 1'b1;
    settle;
    chk("t3_jalr_x0", {62'd0, redirect, stall_pc}, 64'd2);
    step(1);
    set_instr(7'h6F, 3'd0, 5'd9, 5'd9, 1'b0, 32'h240);
    ex_rd = 5'd9; ex_memread = 1'b1;
    settle;
    chk("t3_jal_nostall", {62'd0, redirect, stall_pc}, 64'd2);
    chk("t3_jal_pc", 64'(redirect_pc), 64'h240);
    step(1);
    clr_haz;
    id_valid = 1'b0;

    // 4: ext_stall while WAIT with scnt=1 freezes everything
    set_instr(7'h63, 3'd4, 5'd3, 5'd8, 1'b1, 32'h300);
    ex_rd = 5'd3; ex_memread = 1'b1;
    step(1);
    clr_haz;
    ext_stall = 1'b1;
    settle;
    chk("t4_ext_outputs", {61'd0, stall_pc, bubble_idex, redirect}, 64'd4);
    step(2);
    chk("t4_ext_held", {62'd0, stall_pc, bubble_idex}, 64'd2);
    step(1);
    ext_stall = 1'b0;
    settle;
    chk("t4_release_bubble", 64'(bubble_idex), 64'd1);
    step(1);
    chk("t4_last_bubble", 64'(bubble_idex), 64'd1);
    step(1);
    chk("t4_resolve", {62'd0, redirect, stall_pc}, 64'd2);
    chk("t4_resolve_pc", 64'(redirect_pc), 64'h300);
    step(1);
    id_valid = 1'b0;
    settle;
    chk("t4_counts", {56'd0, branch_cnt, taken_cnt}, {56'd0, 4'd3, 4'd2});

    // 5: reset in WAIT, then a non-branch funct3
    set_instr(7'h63, 3'd5, 5'd1, 5'd4, 1'b1, 32'h400);
    mem_rd = 5'd4; mem_memread = 1'b1;
    step(1);
    clr_haz;
    rst = 1'b1;
    settle;
    chk("t5_rst_outputs", {60'd0, stall_pc, bubble_idex, redirect, flush_ifid}, 64'd0);
    step(1);
    rst = 1'b0;
    id_valid = 1'b0;
    settle;
    chk("t5_counters_cleared", {56'd0, branch_cnt, taken_cnt}, 64'd0);
    set_instr(7'h63, 3'd0, 5'd1, 5'd4, 1'b1, 32'h440);
    settle;
    chk("t5_back_in_run", {62'd0, redirect, stall_pc}, 64'd2);
    step(1);
    set_instr(7'h63, 3'd2, 5'd2, 5'd2, 1'b1, 32'h480);
    ex_rd = 5'd2; ex_memread = 1'b1;
    settle;
    chk("t5_funct3_2_ignored", {62'd0, redirect, stall_pc}, 64'd0);
    step(1);
    clr_haz;
    id_valid = 1'b0;
    settle;
    chk("t5_counts", {56'd0, branch_cnt, taken_cnt}, {56'd0, 4'd1, 4'd1});

    // 6: wrap of 4-bit counters
    set_instr(7'h63, 3'd7, 5'd10, 5'd11, 1'b1, 32'h500);
    for (int i = 0; i < 15; i++) begin
      step(1);
      if (i == 13) chk("t6_all_ones", {56'd0, branch_cnt, taken_cnt}, {56'd0, 4'hF, 4'hF});
    end
    id_valid = 1'b0;
    settle;
    chk("t6_wrapped", {56'd0, branch_cnt, taken_cnt}, 64'd0);
    step(2);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
